// File: rtl/averager_ctrl.sv
// averager_ctrl: run-level sequencer for averager_counter.
// It captures the configuration on start, arms, and waits for a trigger.
// It then gates clken for exactly N frames and holds done until the result is acknowledged.
module averager_ctrl #(
    parameter int unsigned FAST_COUNT_WIDTH = 5,
    parameter int unsigned SLOW_COUNT_WIDTH = 10
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [FAST_COUNT_WIDTH-1:0] cfg_period,
    input  logic [SLOW_COUNT_WIDTH-1:0] cfg_n_avg,
    input  logic                        start,
    input  logic                        abort,
    input  logic                        trig,
    input  logic [FAST_COUNT_WIDTH-1:0] cnt_fast_count,
    input  logic                        done_ack,
    output logic                        restart,
    output logic                        clken,
    output logic [FAST_COUNT_WIDTH-1:0] count_max,
    output logic                        busy,
    output logic                        done,
    output logic [SLOW_COUNT_WIDTH-1:0] n_avg_result,
    output logic [1:0]                  state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [SLOW_COUNT_WIDTH-1:0] SLOW_ONE = {{(SLOW_COUNT_WIDTH-1){1'b0}}, 1'b1};

    state_t                      state_q;
    logic                        restart_q;
    logic                        clken_q;
    logic [FAST_COUNT_WIDTH-1:0] count_max_q;
    logic                        busy_q;
    logic                        done_q;
    logic [SLOW_COUNT_WIDTH-1:0] n_avg_result_q;
    logic [SLOW_COUNT_WIDTH-1:0] frames_q;
    logic [SLOW_COUNT_WIDTH-1:0] target_q;

    logic                        boundary_d;
    logic [SLOW_COUNT_WIDTH-1:0] frames_d;
    logic                        last_frame_d;
    logic [SLOW_COUNT_WIDTH-1:0] target_d;

    // Frame boundary detection and the target value that a start would latch.
    // The restart cycle is excluded because fast_count is still stale then.
    always_comb begin
        boundary_d   = clken_q & ~restart_q & (cnt_fast_count == count_max_q);
        frames_d     = frames_q + SLOW_ONE;
        last_frame_d = boundary_d & (frames_d == target_q);
        target_d     = (cfg_n_avg == '0) ? SLOW_ONE : cfg_n_avg;
    end

    // Sequencer FSM with registered outputs. Abort takes priority over every other event outside IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            restart_q      <= 1'b0;
            clken_q        <= 1'b0;
            count_max_q    <= '0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            n_avg_result_q <= '0;
            frames_q       <= '0;
            target_q       <= '0;
        end else if (abort && (state_q != IDLE)) begin
            state_q   <= IDLE;
            restart_q <= 1'b0;
            clken_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            if (state_q != DONE) begin
                n_avg_result_q <= frames_q;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    restart_q <= 1'b0;
                    clken_q   <= 1'b0;
                    done_q    <= 1'b0;
                    if (start) begin
                        state_q     <= ARM;
                        busy_q      <= 1'b1;
                        count_max_q <= cfg_period;
                        target_q    <= target_d;
                        frames_q    <= '0;
                    end
                end
                ARM: begin
                    if (trig) begin
                        state_q   <= RUN;
                        restart_q <= 1'b1;
                        clken_q   <= 1'b1;
                        frames_q  <= '0;
                    end
                end
                RUN: begin
                    restart_q <= 1'b0;
                    if (boundary_d) begin
                        frames_q <= frames_d;
                    end
                    if (last_frame_d) begin
                        state_q        <= DONE;
                        clken_q        <= 1'b0;
                        busy_q         <= 1'b0;
                        done_q         <= 1'b1;
                        n_avg_result_q <= target_q;
                    end
                end
                DONE: begin
                    clken_q <= 1'b0;
                    if (done_ack) begin
                        done_q <= 1'b0;
                        if (start) begin
                            state_q     <= ARM;
                            busy_q      <= 1'b1;
                            count_max_q <= cfg_period;
                            target_q    <= target_d;
                            frames_q    <= '0;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign restart      = restart_q;
    assign clken        = clken_q;
    assign count_max    = count_max_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign n_avg_result = n_avg_result_q;
    assign state        = state_q;

endmodule

// File: tb/tb_averager_ctrl.sv
// Directed bench for averager_ctrl. It includes a behavioural model of averager_counter.
module tb_averager_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] cfg_period = '0;
    logic [9:0] cfg_n_avg = '0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       trig = 1'b0;
    logic [4:0] fc = '0;
    logic       done_ack = 1'b0;
    logic       restart;
    logic       clken;
    logic [4:0] count_max;
    logic       busy;
    logic       done;
    logic [9:0] n_avg_result;
    logic [1:0] state;

    int unsigned total = 0;
    int unsigned bad = 0;
    int unsigned clken_total = 0;
    int unsigned restart_total = 0;
    int unsigned c0;
    int unsigned r0;
    bit          ok;

    averager_ctrl #(.FAST_COUNT_WIDTH(5), .SLOW_COUNT_WIDTH(10)) dut (
        .clk(clk), .rst(rst), .cfg_period(cfg_period), .cfg_n_avg(cfg_n_avg),
        .start(start), .abort(abort), .trig(trig), .cnt_fast_count(fc),
        .done_ack(done_ack), .restart(restart), .clken(clken), .count_max(count_max),
        .busy(busy), .done(done), .n_avg_result(n_avg_result), .state(state)
    );

    always #5 clk = ~clk;

    // averager_counter model: cleared on restart, otherwise wraps at count_max while enabled.
    always @(posedge clk) begin
        if (restart) fc <= '0;
        else if (clken) fc <= (fc == count_max) ? 5'd0 : fc + 5'd1;
    end

    // Running totals of enabled and restart cycles, sampled mid-cycle.
    always @(negedge clk) begin
        if (clken) clken_total++;
        if (restart) restart_total++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wait_done(input int unsigned limit, output bit seen);
        seen = 1'b0;
        for (int unsigned i = 0; i < limit; i++) begin
            if (done === 1'b1) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
    endtask

    initial begin
        // Reset
        tick(); tick();
        rst = 1'b0;
        chk("rst_state", state, 0);
        chk("rst_clken", clken, 0);
        chk("rst_restart", restart, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_count_max", count_max, 0);
        chk("rst_n_avg", n_avg_result, 0);

        // 1: period 15, 4 frames; the config is changed mid-run and must be ignored
        cfg_period = 5'd15; cfg_n_avg = 10'd4; start = 1'b1;
        tick(); start = 1'b0;
        chk("t1_arm_state", state, 1);
        chk("t1_busy", busy, 1);
        chk("t1_count_max", count_max, 15);
        tick(); tick();
        trig = 1'b1; tick(); trig = 1'b0;
        chk("t1_run_state", state, 2);
        chk("t1_restart", restart, 1);
        chk("t1_clken", clken, 1);
        c0 = clken_total; r0 = restart_total;
        cfg_period = 5'd3; cfg_n_avg = 10'd1;
        tick();
        chk("t1_restart_1cyc", restart, 0);
        chk("t1_count_max_held", count_max, 15);
        wait_done(200, ok);
        chk("t1_done_seen", ok, 1);
        chk("t1_clken_cycles", clken_total - c0, 65);
        chk("t1_restart_pulses", restart_total - r0, 1);
        chk("t1_n_avg", n_avg_result, 4);
        chk("t1_state", state, 3);
        chk("t1_clken_off", clken, 0);
        chk("t1_busy_off", busy, 0);

        // 2: acknowledge, then a trigger in IDLE is ignored
        done_ack = 1'b1; tick(); done_ack = 1'b0;
        chk("t2_state", state, 0);
        chk("t2_done", done, 0);
        trig = 1'b1; tick(); trig = 1'b0;
        chk("t2_trig_state", state, 0);
        chk("t2_trig_restart", restart, 0);
        tick();
        chk("t2_trig_clken", clken, 0);

        // 3: n_avg 0 is treated as 1, and period 0 makes every cycle a boundary
        cfg_period = 5'd0; cfg_n_avg = 10'd0; start = 1'b1;
        tick(); start = 1'b0;
        chk("t3_count_max", count_max, 0);
        trig = 1'b1; tick(); trig = 1'b0;
        c0 = clken_total;
        wait_done(20, ok);
        chk("t3_done_seen", ok, 1);
        chk("t3_clken_cycles", clken_total - c0, 2);
        chk("t3_n_avg", n_avg_result, 1);
        done_ack = 1'b1; tick(); done_ack = 1'b0;

        // 4: abort after 3 boundaries (restart cycle plus 3*16 cycles)
        cfg_period = 5'd15; cfg_n_avg = 10'd8; start = 1'b1;
        tick(); start = 1'b0;
        trig = 1'b1; tick(); trig = 1'b0;
        for (int unsigned i = 0; i < 49; i++) tick();
        chk("t4_pre_abort_state", state, 2);
        abort = 1'b1; tick(); abort = 1'b0;
        chk("t4_state", state, 0);
        chk("t4_clken", clken, 0);
        chk("t4_done", done, 0);
        chk("t4_busy", busy, 0);
        chk("t4_n_avg", n_avg_result, 3);
        for (int unsigned i = 0; i < 5; i++) tick();
        chk("t4_done_never", done, 0);

        // 5: done_ack with start in the same cycle re-arms with the new config
        cfg_n_avg = 10'd1; start = 1'b1;
        tick(); start = 1'b0;
        trig = 1'b1; tick(); trig = 1'b0;
        wait_done(100, ok);
        chk("t5_first_done", ok, 1);
        cfg_n_avg = 10'd2; done_ack = 1'b1; start = 1'b1;
        tick(); done_ack = 1'b0; start = 1'b0;
        chk("t5_arm_state", state, 1);
        chk("t5_done_clr", done, 0);
        chk("t5_busy", busy, 1);
        trig = 1'b1; tick(); trig = 1'b0;
        c0 = clken_total;
        tick(); start = 1'b1; tick(); start = 1'b0;
        chk("t5_start_in_run", state, 2);
        wait_done(200, ok);
        chk("t5_done_seen", ok, 1);
        chk("t5_clken_cycles", clken_total - c0, 33);
        chk("t5_n_avg", n_avg_result, 2);
        done_ack = 1'b1; tick(); done_ack = 1'b0;

        // 6: synchronous reset mid-run, with start held during reset
        cfg_n_avg = 10'd4; start = 1'b1;
        tick(); start = 1'b0;
        trig = 1'b1; tick(); trig = 1'b0;
        for (int unsigned i = 0; i < 5; i++) tick();
        rst = 1'b1; start = 1'b1;
        tick();
        chk("t6_state", state, 0);
        chk("t6_clken", clken, 0);
        chk("t6_restart", restart, 0);
        chk("t6_busy", busy, 0);
        chk("t6_done", done, 0);
        chk("t6_count_max", count_max, 0);
        chk("t6_n_avg", n_avg_result, 0);
        rst = 1'b0; start = 1'b0;
        tick();
        chk("t6_start_ignored", state, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
